// File: rtl/board_rst_seq.sv
// Board reset sequencer: debounced button + PLL-lock reset -> SoC reset, then lagged peripheral reset.
// Optional feature: define RST_SEQ_EVT_CNT_EN to build the saturating button reset event counter.
module board_rst_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int PERIPH_LAG      = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_rst_i,
  output logic             erst_n_o,
  output logic             periph_rst_n_o,
  output logic [1:0]       rst_cause_o,
  output logic [CNT_W-1:0] rst_evt_cnt_o
);

  localparam int SEQ_MAX = (HOLD_CYCLES > PERIPH_LAG) ? HOLD_CYCLES : PERIPH_LAG;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_LAG     = 2'd1,
    ST_RUN     = 2'd2,
    ST_PRESSED = 2'd3
  } state_t;

  logic [1:0]             rst_sync_reg;
  logic                   rst_int_n;
  logic [SYNC_STAGES-1:0] btn_sync_reg;
  logic                   btn_s;
  logic [DB_W-1:0]        db_cnt_reg;
  logic                   btn_db_reg;

  state_t                 state_reg, state_next;
  logic [SEQ_W-1:0]       seq_cnt_reg, seq_cnt_next;
  logic                   erst_reg, erst_next;
  logic                   periph_reg, periph_next;
  logic [1:0]             cause_reg, cause_next;

  // Assert asynchronously with rst_n, release synchronously two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_int_n = rst_sync_reg[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) btn_sync_reg <= '0;
    else            btn_sync_reg <= {btn_sync_reg[SYNC_STAGES-2:0], btn_rst_i};
  end

  assign btn_s = btn_sync_reg[SYNC_STAGES-1];

  // A new level must differ from btn_db for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      db_cnt_reg <= '0;
      btn_db_reg <= 1'b0;
    end else if (btn_s == btn_db_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_reg <= '0;
      btn_db_reg <= btn_s;
    end else begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg   <= ST_HOLD;
      seq_cnt_reg <= '0;
      erst_reg    <= 1'b0;
      periph_reg  <= 1'b0;
      cause_reg   <= 2'b00;
    end else begin
      state_reg   <= state_next;
      seq_cnt_reg <= seq_cnt_next;
      erst_reg    <= erst_next;
      periph_reg  <= periph_next;
      cause_reg   <= cause_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    seq_cnt_next = seq_cnt_reg;
    cause_next   = cause_reg;
    case (state_reg)
      ST_HOLD: begin
        if (btn_db_reg) begin
          state_next   = ST_PRESSED;
          seq_cnt_next = '0;
        end else if (seq_cnt_reg == SEQ_W'(HOLD_CYCLES - 1)) begin
          state_next   = ST_LAG;
          seq_cnt_next = '0;
        end else begin
          seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      ST_LAG: begin
        if (btn_db_reg) begin
          state_next   = ST_PRESSED;
          seq_cnt_next = '0;
        end else if (seq_cnt_reg == SEQ_W'(PERIPH_LAG - 1)) begin
          state_next   = ST_RUN;
          seq_cnt_next = '0;
        end else begin
          seq_cnt_next = seq_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (btn_db_reg) begin
          state_next   = ST_PRESSED;
          seq_cnt_next = '0;
        end
      end
      ST_PRESSED: begin
        seq_cnt_next = '0;
        if (!btn_db_reg) state_next = ST_HOLD;
      end
      default: begin
        state_next   = ST_HOLD;
        seq_cnt_next = '0;
      end
    endcase
    if (state_next == ST_PRESSED && state_reg != ST_PRESSED) cause_next = 2'b01;
    // Outputs are decoded from the next state so they switch with the transition.
    erst_next   = (state_next == ST_LAG) || (state_next == ST_RUN);
    periph_next = (state_next == ST_RUN);
  end

  assign erst_n_o       = erst_reg;
  assign periph_rst_n_o = periph_reg;
  assign rst_cause_o    = cause_reg;

`ifdef RST_SEQ_EVT_CNT_EN
  logic [CNT_W-1:0] evt_cnt_reg;
  logic             press_entry;

  assign press_entry = (state_next == ST_PRESSED) && (state_reg != ST_PRESSED);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                         evt_cnt_reg <= '0;
    else if (press_entry && !(&evt_cnt_reg)) evt_cnt_reg <= evt_cnt_reg + 1'b1;
  end

  assign rst_evt_cnt_o = evt_cnt_reg;
`else
  assign rst_evt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_board_rst_seq.sv
// Directed bench for board_rst_seq with short timing parameters; edge numbers are hand-derived.
// Honours RST_SEQ_EVT_CNT_EN for the expected event-counter values.
module tb_board_rst_seq;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 5;
  localparam int HOLD_CYCLES     = 8;
  localparam int PERIPH_LAG      = 4;
  localparam int CNT_W           = 2;

`ifdef RST_SEQ_EVT_CNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_rst_i;
  logic             erst_n_o;
  logic             periph_rst_n_o;
  logic [1:0]       rst_cause_o;
  logic [CNT_W-1:0] rst_evt_cnt_o;

  int checks = 0;
  int errors = 0;

  board_rst_seq #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .PERIPH_LAG     (PERIPH_LAG),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_rst_i     (btn_rst_i),
    .erst_n_o      (erst_n_o),
    .periph_rst_n_o(periph_rst_n_o),
    .rst_cause_o   (rst_cause_o),
    .rst_evt_cnt_o (rst_evt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] evt_exp(input int presses);
    if (!EVT_EN) return 32'd0;
    return (presses > 3) ? 32'd3 : 32'(presses);
  endfunction

  task automatic power_up_timing(input string tag);
    step(9);
    check({tag, "_erst_e9"}, erst_n_o, 0);
    step(1);
    check({tag, "_erst_e10"}, erst_n_o, 1);
    check({tag, "_periph_e10"}, periph_rst_n_o, 0);
    step(3);
    check({tag, "_periph_e13"}, periph_rst_n_o, 0);
    step(1);
    check({tag, "_periph_e14"}, periph_rst_n_o, 1);
    check({tag, "_cause"}, rst_cause_o, 2'b00);
    $display("%s: power-up release sequence checked", tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_rst_i = 1'b0;

    // 1. reset values and power-up release
    step(3);
    check("rst_erst", erst_n_o, 0);
    check("rst_periph", periph_rst_n_o, 0);
    check("rst_cause", rst_cause_o, 2'b00);
    check("rst_evt", rst_evt_cnt_o, 0);
    rst_n = 1'b1;
    power_up_timing("pwr1");

    // 2. glitch shorter than the debounce window
    btn_rst_i = 1'b1;
    step(3);
    btn_rst_i = 1'b0;
    step(15);
    check("glitch_erst", erst_n_o, 1);
    check("glitch_periph", periph_rst_n_o, 1);
    check("glitch_cause", rst_cause_o, 2'b00);
    check("glitch_evt", rst_evt_cnt_o, 0);
    $display("glitch: 3-edge pulse ignored");

    // 3. long press from RUN
    btn_rst_i = 1'b1;
    step(7);
    check("press_erst_e7", erst_n_o, 1);
    step(1);
    check("press_erst_e8", erst_n_o, 0);
    check("press_periph_e8", periph_rst_n_o, 0);
    check("press_cause", rst_cause_o, 2'b01);
    check("press_evt", rst_evt_cnt_o, evt_exp(1));
    step(12);
    btn_rst_i = 1'b0;
    step(8);
    check("rel_erst_e8", erst_n_o, 0);
    step(7);
    check("rel_erst_e15", erst_n_o, 0);
    step(1);
    check("rel_erst_e16", erst_n_o, 1);
    check("rel_periph_e16", periph_rst_n_o, 0);
    step(3);
    check("rel_periph_e19", periph_rst_n_o, 0);
    step(1);
    check("rel_periph_e20", periph_rst_n_o, 1);
    check("rel_cause", rst_cause_o, 2'b01);
    $display("press: 20-edge press and release checked");

    // 5. re-press debounced at HOLD count 5 restarts the hold
    btn_rst_i = 1'b1;
    step(8);
    check("hp_press_erst", erst_n_o, 0);
    check("hp_press_evt", rst_evt_cnt_o, evt_exp(2));
    btn_rst_i = 1'b0;
    step(6);
    btn_rst_i = 1'b1;
    step(2);
    check("hp_hold_e8", erst_n_o, 0);
    step(5);
    check("hp_hold_e13", erst_n_o, 0);
    step(1);
    check("hp_repress_evt", rst_evt_cnt_o, evt_exp(3));
    step(2);
    check("hp_no_early_e16", erst_n_o, 0);
    check("hp_no_early_periph", periph_rst_n_o, 0);
    btn_rst_i = 1'b0;
    step(15);
    check("hp_rel_erst_e15", erst_n_o, 0);
    step(1);
    check("hp_rel_erst_e16", erst_n_o, 1);
    check("hp_rel_cause", rst_cause_o, 2'b01);
    $display("hold_press: hold restarted after re-press");

    // 4. asynchronous reset two edges into LAG
    step(2);
    check("lag_erst", erst_n_o, 1);
    check("lag_periph", periph_rst_n_o, 0);
    rst_n = 1'b0;
    #1;
    check("async_erst", erst_n_o, 0);
    check("async_periph", periph_rst_n_o, 0);
    check("async_cause", rst_cause_o, 2'b00);
    check("async_evt", rst_evt_cnt_o, 0);
    step(2);
    rst_n = 1'b1;
    power_up_timing("pwr2");

    // 6. event counter saturation
    for (int p = 1; p <= 4; p++) begin
      btn_rst_i = 1'b1;
      step(8);
      check($sformatf("sat%0d_erst", p), erst_n_o, 0);
      check($sformatf("sat%0d_cause", p), rst_cause_o, 2'b01);
      check($sformatf("sat%0d_evt", p), rst_evt_cnt_o, evt_exp(p));
      btn_rst_i = 1'b0;
      step(20);
      check($sformatf("sat%0d_periph", p), periph_rst_n_o, 1);
      $display("sat: press %0d event count %0d", p, rst_evt_cnt_o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
